mul8_nibble_seq: RTL and testbench

Sequential 8x8 unsigned multiplier for the processor's multiply path. It produces a 16-bit product by time-multiplexing one external 4x4 combinational array multiplier over four cycles, one nibble-pair partial product per cycle, and accumulates the shifted results. It sits directly downstream of the 4x4 array multiplier: it drives that multiplier's operand nibbles and consumes its 8-bit product. The ALU control issues work through a start/busy/done handshake.

---
 rtl/mul8_nibble_seq.sv | 125 ++++++++++++
 tb/tb_mul8_nibble_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mul8_nibble_seq.sv
// Sequential 8x8 unsigned multiplier that runs one shared external 4x4 array
// multiplier over four cycles and accumulates the shifted nibble products.
module mul8_nibble_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [3:0]  mul_a,
   output logic [3:0]  mul_b,
   input  logic [7:0]  mul_p,
   output logic        busy,
   output logic        done,
   output logic [15:0] prod
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic [1:0]  step_q, step_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] prod_q, prod_d;
   logic [15:0] part_w;
   logic [15:0] sum_w;

   // Nibble selection and partial-product alignment for the current step.
   // Step order: lo*lo, hi*lo, lo*hi, hi*hi.
   always_comb begin
      // NOTE: every combinationally driven signal gets a default first, so no
      // path through the case statements leaves it unassigned (no latches).
      mul_a  = 4'h0;
      mul_b  = 4'h0;
      part_w = 16'h0000;
      if (state_q == ST_RUN) begin
         unique case (step_q)
            2'd0: begin
               mul_a  = a_q[3:0];
               mul_b  = b_q[3:0];
               part_w = {8'h00, mul_p};
            end
            2'd1: begin
               mul_a  = a_q[7:4];
               mul_b  = b_q[3:0];
               part_w = {4'h0, mul_p, 4'h0};
            end
            2'd2: begin
               mul_a  = a_q[3:0];
               mul_b  = b_q[7:4];
               part_w = {4'h0, mul_p, 4'h0};
            end
            default: begin
               mul_a  = a_q[7:4];
               mul_b  = b_q[7:4];
               part_w = {mul_p, 8'h00};
            end
         endcase
      end
   end

   // Cannot overflow: the largest final sum is 0xFF*0xFF = 0xFE01.
   assign sum_w = acc_q + part_w;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      step_d  = step_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               acc_d   = 16'h0000;
               step_d  = 2'd0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d  = sum_w;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               prod_d  = sum_w;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         step_q  <= 2'd0;
         acc_q   <= 16'h0000;
         prod_q  <= 16'h0000;
      end else begin
         // NOTE: state registers use non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         step_q  <= step_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
      end
   end

   // Status outputs decode registered state only; done never sees start directly.
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign prod = prod_q;

endmodule

// File: tb/tb_mul8_nibble_seq.sv
// Scoreboard bench for mul8_nibble_seq: the driver queues expected products and
// completion cycles, and a monitor checks each done pulse against the queue.
module tb_mul8_nibble_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [3:0]  mul_a;
   logic [3:0]  mul_b;
   logic [7:0]  mul_p;
   logic        busy;
   logic        done;
   logic [15:0] prod;

   typedef struct {
      logic [15:0] prod;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_vec  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   logic [15:0] last_prod = 16'h0000;

   mul8_nibble_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .mul_a (mul_a),
      .mul_b (mul_b),
      .mul_p (mul_p),
      .busy  (busy),
      .done  (done),
      .prod  (prod)
   );

   // Behavioural stand-in for the external 4x4 array multiplier.
   assign mul_p = {4'h0, mul_a} * {4'h0, mul_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("prod", {16'h0, prod}, {16'h0, e.prod});
            check("done_latency", cyc, e.cyc);
         end
      end
   end

   // Called at a negedge. nib packs the expected (mul_a,mul_b) pairs for steps 0..3.
   task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic [15:0] exp_p, input bit chk_nib,
                        input logic [31:0] nib, input bit hold_start);
      a     = op_a;
      b     = op_b;
      start = 1'b1;
      sb_q.push_back('{exp_p, cyc + 5});
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("run_busy", {31'h0, busy}, 32'd1);
         check("run_no_done", {31'h0, done}, 32'd0);
         check("prod_hold", {16'h0, prod}, {16'h0, last_prod});
         if (chk_nib) begin
            check("mul_a_seq", {28'h0, mul_a}, {28'h0, nib[31-8*i -: 4]});
            check("mul_b_seq", {28'h0, mul_b}, {28'h0, nib[27-8*i -: 4]});
         end
         if (hold_start) begin
            start = 1'b1;
            a     = 8'h55;
            b     = 8'h55;
         end
         @(negedge clk);
      end
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      check("done_busy_low", {31'h0, busy}, 32'd0);
      check("done_pulse", {31'h0, done}, 32'd1);
      check("done_nib_zero", {24'h0, mul_a, mul_b}, 32'd0);
      last_prod = exp_p;
      @(negedge clk);
      check("done_one_cycle", {31'h0, done}, 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_prod", {16'h0, prod}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_done", {31'h0, done}, 32'd0);
      check("rst_mul", {24'h0, mul_a, mul_b}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_no_done", {30'h0, busy, done}, 32'd0);
      end

      do_op(8'h12, 8'h34, 16'h03A8, 1'b1, 32'h24_14_23_13, 1'b0);
      do_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, 32'h0, 1'b0);
      do_op(8'h00, 8'hA5, 16'h0000, 1'b0, 32'h0, 1'b0);
      do_op(8'h0F, 8'h10, 16'h00F0, 1'b0, 32'h0, 1'b1);
      repeat (3) @(negedge clk);

      // Continuous start: results land at 5-cycle intervals.
      a     = 8'h03;
      b     = 8'h07;
      start = 1'b1;
      sb_q.push_back('{16'h0015, cyc + 5});
      sb_q.push_back('{16'h0015, cyc + 10});
      sb_q.push_back('{16'h0015, cyc + 15});
      repeat (15) @(negedge clk);
      start = 1'b0;
      last_prod = 16'h0015;
      @(negedge clk);
      check("b2b_prod_hold", {16'h0, prod}, 32'h0015);

      // Reset in the middle of RUN step 2 discards the operation.
      a     = 8'hAB;
      b     = 8'hCD;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_run_step2_a", {28'h0, mul_a}, 32'hB);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", {31'h0, busy}, 32'd0);
      check("midrst_done", {31'h0, done}, 32'd0);
      check("midrst_prod", {16'h0, prod}, 32'h0);
      check("midrst_mul", {24'h0, mul_a, mul_b}, 32'd0);
      last_prod = 16'h0000;
      repeat (6) @(negedge clk);
      do_op(8'hAB, 8'hCD, 16'h88EF, 1'b0, 32'h0, 1'b0);

      repeat (4) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
